// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - shared constants, FSM state type and row helpers for the keypad scanner
//
// Contents:
//   NUM_COL / NUM_LIN  matrix geometry (5 columns a..e, 7 rows 0..6)
//   IDX_W              width of column/row indices
//   estado_t           scanner FSM states
//   menor_linha()      index of the lowest active-low row
//   proxima_coluna()   column index advance with wrap 4 -> 0
package matriz_pkg;

    localparam int NUM_COL = 5;
    localparam int NUM_LIN = 7;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        VARRE   = 2'd0,
        FILTRA  = 2'd1,
        REPORTA = 2'd2,
        SOLTA   = 2'd3
    } estado_t;

    // Lowest row index wins when several keys in one column are down.
    function automatic logic [IDX_W-1:0] menor_linha(input logic [NUM_LIN-1:0] lin_n);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LIN - 1; i >= 0; i--) begin
            if (!lin_n[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] proxima_coluna(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(NUM_COL - 1)) ? '0 : k + IDX_W'(1);
    endfunction

endpackage

// File: rtl/contador_estavel.sv
// rtl/contador_estavel.sv - saturating count of consecutive stable samples
//
// Ports:
//   clk_i         rising-edge clock
//   rst_n_i       synchronous active-low reset, clears the count
//   limpa_i       clear the count (has priority over increment)
//   incrementa_i  this cycle's sample is stable
//   atingiu_o     this increment brings the run to ALVO stable samples
module contador_estavel
    #(
        parameter int ALVO = 8
    )
    (
        input  logic clk_i,
        input  logic rst_n_i,
        input  logic limpa_i,
        input  logic incrementa_i,
        output logic atingiu_o
    );

    localparam int CW = (ALVO > 1) ? $clog2(ALVO + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (limpa_i) begin
            cnt_d = '0;
        end else if (incrementa_i && (cnt_q != CW'(ALVO))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the FSM can leave on the very sample that completes the run.
    assign atingiu_o = incrementa_i && !limpa_i && (cnt_q >= CW'(ALVO - 1));

endmodule

// File: rtl/leitor_teclado_matriz.sv
// rtl/leitor_teclado_matriz.sv - 5x7 matrix keypad scanner with debounce and valid/ack output
//
// Build option: LEITOR_DEBOUNCE_EN enables the FILTRA press filter and the
// DEB_CICLOS release count; without it a press is reported on the first
// sample and a release is accepted on the first all-high sample.
//
// Ports:
//   clk_div  rising-edge clock
//   rst_n    synchronous active-low reset
//   col_n    column drive, active-low one-hot (bit 0 = column a)
//   lin_n    row sense, active-low (bit 0 = row 0)
//   valido   key coordinate available
//   ack      consumer accepts the coordinate
//   col_idx  column of the accepted key
//   lin_idx  row of the accepted key
//   ocupado  high outside VARRE
module leitor_teclado_matriz
    import matriz_pkg::*;
    #(
        parameter int SETTLE_CICLOS = 2,
        parameter int DEB_CICLOS    = 8
    )
    (
        input  logic               clk_div,
        input  logic               rst_n,
        output logic [NUM_COL-1:0] col_n,
        input  logic [NUM_LIN-1:0] lin_n,
        output logic               valido,
        input  logic               ack,
        output logic [IDX_W-1:0]   col_idx,
        output logic [IDX_W-1:0]   lin_idx,
        output logic               ocupado
    );

`ifdef LEITOR_DEBOUNCE_EN
    localparam int DEB_ATIVO = DEB_CICLOS;
`else
    // One all-high sample releases; DEB_CICLOS is referenced only so both
    // builds expose the same parameter set.
    localparam int DEB_ATIVO = (DEB_CICLOS >= 1) ? 1 : 1;
`endif

    localparam int SW = (SETTLE_CICLOS > 0) ? $clog2(SETTLE_CICLOS + 1) : 1;

    estado_t          estado_q;
    logic [IDX_W-1:0] col_q;
    logic [SW-1:0]    settle_q;
    logic [IDX_W-1:0] lin_lat_q;
    logic             valido_q;
    logic             ocupado_q;
    logic [IDX_W-1:0] col_idx_q;
    logic [IDX_W-1:0] lin_idx_q;

    logic             alguma_baixa;
    logic             todas_altas;
    logic [IDX_W-1:0] linha_atual;
    logic             casa;
    logic             cont_limpa;
    logic             cont_inc;
    logic             cont_fim;

    assign alguma_baixa = ~&lin_n;
    assign todas_altas  = &lin_n;
    assign linha_atual  = menor_linha(lin_n);
    assign casa         = alguma_baixa && (linha_atual == lin_lat_q);

    // Counter is shared: FILTRA counts matching presses, SOLTA counts all-high
    // samples; every other state keeps it cleared so each run starts at zero.
    always_comb begin
        cont_limpa = 1'b0;
        cont_inc   = 1'b0;
        case (estado_q)
            FILTRA: begin
                cont_inc   = casa;
                cont_limpa = !casa;
            end
            SOLTA: begin
                cont_inc   = todas_altas;
                cont_limpa = !todas_altas;
            end
            default: begin
                cont_limpa = 1'b1;
            end
        endcase
    end

    contador_estavel #(
        .ALVO (DEB_ATIVO)
    ) u_contador (
        .clk_i        (clk_div),
        .rst_n_i      (rst_n),
        .limpa_i      (cont_limpa),
        .incrementa_i (cont_inc),
        .atingiu_o    (cont_fim)
    );

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            estado_q  <= VARRE;
            col_q     <= '0;
            settle_q  <= '0;
            lin_lat_q <= '0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            col_idx_q <= '0;
            lin_idx_q <= '0;
        end else begin
            case (estado_q)
                VARRE: begin
                    if (settle_q != SW'(SETTLE_CICLOS)) begin
                        settle_q <= settle_q + SW'(1);
                    end else begin
                        settle_q <= '0;
                        if (alguma_baixa) begin
                            lin_lat_q <= linha_atual;
                            ocupado_q <= 1'b1;
`ifdef LEITOR_DEBOUNCE_EN
                            estado_q  <= FILTRA;
`else
                            estado_q  <= REPORTA;
                            valido_q  <= 1'b1;
                            col_idx_q <= col_q;
                            lin_idx_q <= linha_atual;
`endif
                        end else begin
                            col_q <= proxima_coluna(col_q);
                        end
                    end
                end
                FILTRA: begin
                    if (!casa) begin
                        estado_q  <= VARRE;
                        ocupado_q <= 1'b0;
                        col_q     <= proxima_coluna(col_q);
                    end else if (cont_fim) begin
                        estado_q  <= REPORTA;
                        valido_q  <= 1'b1;
                        col_idx_q <= col_q;
                        lin_idx_q <= lin_lat_q;
                    end
                end
                REPORTA: begin
                    if (ack) begin
                        estado_q <= SOLTA;
                        valido_q <= 1'b0;
                    end
                end
                SOLTA: begin
                    if (cont_fim) begin
                        estado_q  <= VARRE;
                        ocupado_q <= 1'b0;
                        col_q     <= proxima_coluna(col_q);
                    end
                end
                default: begin
                    estado_q <= VARRE;
                end
            endcase
        end
    end

    assign col_n   = ~(NUM_COL'(1) << col_q);
    assign valido  = valido_q;
    assign ocupado = ocupado_q;
    assign col_idx = col_idx_q;
    assign lin_idx = lin_idx_q;

endmodule

// File: doc/leitor_teclado_matriz.md
LEITOR_TECLADO_MATRIZ -- requirements
Module: leitor_teclado_matriz

Interface
REQ-001 Parameter SETTLE_CICLOS, default 2: cycles a column is driven before its rows are sampled.
REQ-002 Parameter DEB_CICLOS, default 8: consecutive stable samples needed to accept a press or a release.
REQ-003 clk_div  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 col_n  output  5  column drive, active-low one-hot; bit 0 = column a, bit 4 = column e.
REQ-006 lin_n  input  7  row sense, active-low with external pull-ups; bit 0 = row 0.
REQ-007 valido  output  1  a key coordinate is available.
REQ-008 ack  input  1  consumer accepts the coordinate.
REQ-009 col_idx  output  3  column of the accepted key, 0..4.
REQ-010 lin_idx  output  3  row of the accepted key, 0..6.
REQ-011 ocupado  output  1  high in every state except VARRE.

Function
REQ-012 FSM states SHALL be VARRE, FILTRA, REPORTA and SOLTA.
REQ-013 VARRE: drive column k low for SETTLE_CICLOS cycles, then sample lin_n.
- All rows high: k advances, wrapping 4 -> 0.
- Any row low: latch the lowest-index low row and go to FILTRA.
REQ-014 FILTRA: keep column k driven and count consecutive cycles in which the lowest-index low row equals the latched row.
- Mismatch or all rows high: counter cleared, return to VARRE with k+1.
- Count reaches DEB_CICLOS: go to REPORTA.
REQ-015 REPORTA: valido high, col_idx = k, lin_idx = latched row; outputs SHALL be stable until handshake.
REQ-016 Handshake: valido and ack both high on a rising edge completes the transfer; valido SHALL be low the next cycle and the FSM SHALL go to SOLTA.
REQ-017 ack while valido is low SHALL be ignored.
REQ-018 SOLTA: keep column k driven until all rows read high for DEB_CICLOS consecutive cycles, then return to VARRE with k+1; a held key SHALL be reported only once.
REQ-019 Multiple keys in the same column: lowest row index wins. Keys in other columns are not seen until their column is scanned.
REQ-020 Exactly one col_n bit SHALL be low in every cycle.
REQ-021 Minimum latency from a stable press to valido SHALL be SETTLE_CICLOS + 1 + DEB_CICLOS cycles, with the column already selected.

Reset
REQ-022 While rst_n is low at a clock edge, the block SHALL enter VARRE with k=0 and:
- col_n = 5'b11110
- valido = 0, ocupado = 0, col_idx = 0, lin_idx = 0
- all counters = 0
REQ-023 Reset SHALL take effect from any state, including REPORTA with a pending, unacknowledged coordinate; that coordinate SHALL be discarded.

Configuration
REQ-024 Macro LEITOR_DEBOUNCE_EN defined: FILTRA and the SOLTA stability count SHALL use DEB_CICLOS as specified above.
REQ-025 Macro LEITOR_DEBOUNCE_EN undefined:
- FILTRA is bypassed: the VARRE sample goes straight to REPORTA.
- SOLTA exits on the first all-high sample.
- DEB_CICLOS has no effect.

Structure
REQ-026 Package matriz_pkg SHALL hold NUM_COL=5, NUM_LIN=7, the FSM state typedef and the index width constant (3); the display and attack blocks share the same constants.
REQ-027 Sub-module contador_estavel SHALL implement the saturating stability counter (inputs: clear, increment; output: reached DEB_CICLOS) and be used in both FILTRA and SOLTA.

Verification
REQ-028 Reset with no keys pressed -> col_n cycles 11110, 11101, 11011, 10111, 01111, 11110, each column held SETTLE_CICLOS+1 cycles; valido stays 0.
REQ-029 Key (col 2, row 5) held, ack asserted on the first valido cycle -> col_idx=2, lin_idx=5, valido high exactly 1 cycle; no second report until release.
REQ-030 Bounce on row 3 (low 3 cycles, high 1, low 10), with LEITOR_DEBOUNCE_EN -> a single report with lin_idx=3; the 3-cycle glitch alone produces no report.
REQ-031 Rows 1 and 4 low in column 0 -> lin_idx=1; ack withheld 20 cycles -> valido, col_idx and lin_idx held unchanged and col_n stays 11110.
REQ-032 rst_n low for one cycle during REPORTA -> next cycle valido=0 and col_n=11110; the key still held is re-detected and reported again.
REQ-033 Build without LEITOR_DEBOUNCE_EN, key (col 4, row 6) -> valido exactly SETTLE_CICLOS+1 cycles after column 4 is selected.
